// File: rtl/gtech_prbs_engine.sv
// PRBS7/15/23/31 generator plus self-synchronising checker; GTECH_PRBS_INVERT_EN selects inverted polarity.
// Z registered one cycle after load, stalls on Z_READY low; checker has no backpressure, status one cycle after A.
module gtech_prbs_engine #(
  parameter int POLY       = 7,
  parameter int DW         = 8,
  parameter int LOCK_BITS  = 64,
  parameter int LOSS_WORDS = 4
) (
  input  logic          CP,
  input  logic          RST,
  input  logic          GEN_EN,
  output logic [DW-1:0] Z,
  output logic          Z_VALID,
  input  logic          Z_READY,
  input  logic [DW-1:0] A,
  input  logic          A_VALID,
  input  logic          CLR_ERR,
  output logic          LOCKED,
  output logic [15:0]   ERR_CNT,
  output logic          ERR_PULSE
);

  localparam int T2 = (POLY == 7)  ? 6  :
                      (POLY == 15) ? 14 :
                      (POLY == 23) ? 18 : 28;
  localparam int MW = $clog2(LOCK_BITS + 1);
  localparam int LW = $clog2(LOSS_WORDS + 1);
  localparam int NW = $clog2(DW + 1);
  localparam logic [MW-1:0] LOCK_MAX = MW'(LOCK_BITS);
  localparam logic [LW-1:0] LOSS_MAX = LW'(LOSS_WORDS);

  generate
    if (!(POLY == 7 || POLY == 15 || POLY == 23 || POLY == 31)) begin : g_bad_poly
      $error("gtech_prbs_engine: POLY must be 7, 15, 23 or 31");
    end
  endgenerate

  typedef enum logic {ST_SEARCH, ST_LOCKED} state_t;

  state_t          state, state_nxt;
  logic [POLY-1:0] gen_lfsr, gen_nxt;
  logic [DW-1:0]   gen_word;
  logic            gen_load;
  logic [POLY-1:0] chk_lfsr, chk_nxt, chk_d;
  logic [MW-1:0]   match_cnt, match_nxt, match_d;
  logic [LW-1:0]   loss_cnt, loss_d, loss_inc;
  logic [NW-1:0]   nerr;
  logic [15:0]     err_d;
  logic [16:0]     err_sum;
  logic            pulse_d;
  logic [DW-1:0]   a_in;
  logic            pred_bit;
  logic            miss_bit;

  // Generator: DW LFSR steps unrolled in one cycle
  always_comb begin
    gen_nxt  = gen_lfsr;
    gen_word = '0;
    for (int i = 0; i < DW; i++) begin
      gen_word[i] = gen_nxt[POLY-1] ^ gen_nxt[T2-1];
      gen_nxt     = {gen_nxt[POLY-2:0], gen_word[i]};
    end
  end

  assign gen_load = GEN_EN && (!Z_VALID || Z_READY);

  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      gen_lfsr <= '1;
      Z        <= '0;
      Z_VALID  <= 1'b0;
    end else if (gen_load) begin
      gen_lfsr <= gen_nxt;
`ifdef GTECH_PRBS_INVERT_EN
      Z        <= ~gen_word;
`else
      Z        <= gen_word;
`endif
      Z_VALID  <= 1'b1;
    end else if (Z_READY) begin
      Z_VALID  <= 1'b0;
    end
  end

`ifdef GTECH_PRBS_INVERT_EN
  assign a_in = ~A;
`else
  assign a_in = A;
`endif

  // Checker word step: SEARCH seeds from received bits, LOCKED free-runs on predictions
  always_comb begin
    chk_nxt   = chk_lfsr;
    match_nxt = match_cnt;
    nerr      = '0;
    pred_bit  = 1'b0;
    miss_bit  = 1'b0;
    for (int i = 0; i < DW; i++) begin
      pred_bit = chk_nxt[POLY-1] ^ chk_nxt[T2-1];
      miss_bit = a_in[i] ^ pred_bit;
      if (state == ST_SEARCH) begin
        if (miss_bit)
          match_nxt = '0;
        else if (match_nxt != LOCK_MAX)
          match_nxt = match_nxt + MW'(1);
        chk_nxt = {chk_nxt[POLY-2:0], a_in[i]};
      end else begin
        nerr    = nerr + NW'(miss_bit);
        chk_nxt = {chk_nxt[POLY-2:0], pred_bit};
      end
    end
  end

  always_comb begin
    state_nxt = state;
    chk_d     = chk_lfsr;
    match_d   = match_cnt;
    loss_d    = loss_cnt;
    err_d     = ERR_CNT;
    pulse_d   = 1'b0;
    loss_inc  = loss_cnt + LW'(1);
    err_sum   = {1'b0, ERR_CNT} + 17'(nerr);
    if (A_VALID) begin
      chk_d = chk_nxt;
      if (state == ST_SEARCH) begin
        match_d = match_nxt;
        if (match_nxt == LOCK_MAX) begin
          state_nxt = ST_LOCKED;
          loss_d    = '0;
        end
      end else begin
        err_d   = err_sum[16] ? 16'hFFFF : err_sum[15:0];
        pulse_d = (nerr != '0);
        if (nerr != '0) begin
          loss_d = loss_inc;
          if (loss_inc == LOSS_MAX) begin
            state_nxt = ST_SEARCH;
            match_d   = '0;
          end
        end else begin
          loss_d = '0;
        end
      end
    end
    if (CLR_ERR)
      err_d = '0;
  end

  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      state     <= ST_SEARCH;
      chk_lfsr  <= '1;
      match_cnt <= '0;
      loss_cnt  <= '0;
      ERR_CNT   <= '0;
      ERR_PULSE <= 1'b0;
    end else begin
      state     <= state_nxt;
      chk_lfsr  <= chk_d;
      match_cnt <= match_d;
      loss_cnt  <= loss_d;
      ERR_CNT   <= err_d;
      ERR_PULSE <= pulse_d;
    end
  end

  assign LOCKED = (state == ST_LOCKED);

endmodule

// File: tb/tb_gtech_prbs_engine.sv
// Directed bench for gtech_prbs_engine: loopback lock, stall, error injection, loss/relock, reset.
module tb_gtech_prbs_engine;

  typedef struct packed {
    logic        locked;
    logic [15:0] err;
    logic        pulse;
  } chk_t;

`ifdef GTECH_PRBS_INVERT_EN
  localparam logic [7:0] FIRST_W  = 8'hBF;
  localparam logic [7:0] SECOND_W = 8'hCF;
`else
  localparam logic [7:0] FIRST_W  = 8'h40;
  localparam logic [7:0] SECOND_W = 8'h30;
`endif

  logic        clk = 1'b0;
  logic        rst, gen_en, z_ready, clr_err, lb_en;
  logic [7:0]  flip;
  logic [7:0]  z0, a0;
  logic        zv0, av0, lk0, pl0;
  logic [15:0] err0;

  logic [7:0]  zx  [3];
  logic        zvx [3];
  logic        lkx [3];
  logic        plx [3];
  logic [15:0] ex  [3];

  int polys [3] = '{15, 23, 31};
  int taps  [3] = '{14, 18, 28};

  int n_chk;
  int n_pass;

  logic [7:0]  q_z [$];
  chk_t        q_chk [$];
  logic [31:0] gm;

  always #5 clk = ~clk;

  assign a0  = z0 ^ flip;
  assign av0 = lb_en && zv0 && z_ready;

  gtech_prbs_engine #(.POLY(7), .DW(8), .LOCK_BITS(64), .LOSS_WORDS(4)) u_dut (
    .CP(clk), .RST(rst), .GEN_EN(gen_en),
    .Z(z0), .Z_VALID(zv0), .Z_READY(z_ready),
    .A(a0), .A_VALID(av0), .CLR_ERR(clr_err),
    .LOCKED(lk0), .ERR_CNT(err0), .ERR_PULSE(pl0)
  );

  for (genvar g = 0; g < 3; g++) begin : g_poly
    localparam int P = (g == 0) ? 15 : (g == 1) ? 23 : 31;
    gtech_prbs_engine #(.POLY(P), .DW(8), .LOCK_BITS(64), .LOSS_WORDS(4)) u_dut (
      .CP(clk), .RST(rst), .GEN_EN(1'b1),
      .Z(zx[g]), .Z_VALID(zvx[g]), .Z_READY(1'b1),
      .A(zx[g]), .A_VALID(zvx[g]), .CLR_ERR(1'b0),
      .LOCKED(lkx[g]), .ERR_CNT(ex[g]), .ERR_PULSE(plx[g])
    );
  end

  // Reference LFSR: independent bit-serial model of the tap equations
  function automatic logic [7:0] model_word(input int poly, input int t2,
                                             input logic [31:0] s_in, output logic [31:0] s_out);
    logic [31:0] s;
    logic [31:0] mask;
    logic        b;
    logic [7:0]  w;
    s    = s_in;
    mask = (32'h1 << poly) - 32'h1;
    w    = '0;
    for (int i = 0; i < 8; i++) begin
      b    = s[poly-1] ^ s[t2-1];
      w[i] = b;
      s    = ((s << 1) | {31'b0, b}) & mask;
    end
    s_out = s;
`ifdef GTECH_PRBS_INVERT_EN
    return ~w;
`else
    return w;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_gen(input int n);
    for (int i = 0; i < n; i++) q_z.push_back(model_word(7, 6, gm, gm));
  endtask

  task automatic expect_chk(input logic l, input logic [15:0] e, input logic p);
    chk_t t;
    t.locked = l;
    t.err    = e;
    t.pulse  = p;
    q_chk.push_back(t);
  endtask

  task automatic cyc();
    logic [7:0] wexp;
    chk_t       t;
    if (zv0 && z_ready && q_z.size() > 0) begin
      wexp = q_z.pop_front();
      check("z_word", 64'(z0), 64'(wexp));
    end
    @(posedge clk);
    #1;
    if (q_chk.size() > 0) begin
      t = q_chk.pop_front();
      check("locked", 64'(lk0), 64'(t.locked));
      check("err_cnt", 64'(err0), 64'(t.err));
      check("err_pulse", 64'(pl0), 64'(t.pulse));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_z"}, 64'(z0), 64'(0));
    check({tag, "_z_valid"}, 64'(zv0), 64'(0));
    check({tag, "_locked"}, 64'(lk0), 64'(0));
    check({tag, "_err_cnt"}, 64'(err0), 64'(0));
    check({tag, "_err_pulse"}, 64'(pl0), 64'(0));
  endtask

  initial begin
    logic [31:0] s_out;
    logic [7:0]  wexp;
    n_chk   = 0;
    n_pass  = 0;
    rst     = 1'b1;
    gen_en  = 1'b1;
    z_ready = 1'b1;
    clr_err = 1'b0;
    lb_en   = 1'b1;
    flip    = 8'h00;
    gm      = 32'h7F;
    push_gen(1100);

    cyc();
    cyc();
    check_reset_vals("reset");

    rst = 1'b0;
    cyc();
    check("first_valid", 64'(zv0), 64'(1));
    check("first_word", 64'(z0), 64'(FIRST_W));
    for (int g = 0; g < 3; g++) begin
      wexp = model_word(polys[g], taps[g], (32'h1 << polys[g]) - 32'h1, s_out);
      check("poly_first_word", 64'(zx[g]), 64'(wexp));
    end

    // Stall the first word for three cycles
    z_ready = 1'b0;
    repeat (3) begin
      cyc();
      check("stall_word", 64'(z0), 64'(FIRST_W));
      check("stall_valid", 64'(zv0), 64'(1));
    end

    // Loopback lock: LOCKED rises after the 8th word
    z_ready = 1'b1;
    for (int w = 1; w <= 8; w++) begin
      expect_chk(w == 8, 16'd0, 1'b0);
      cyc();
      if (w == 1) check("second_word", 64'(z0), 64'(SECOND_W));
    end
    repeat (992) begin
      expect_chk(1'b1, 16'd0, 1'b0);
      cyc();
    end
    for (int g = 0; g < 3; g++) begin
      check("poly_locked", 64'(lkx[g]), 64'(1));
      check("poly_err_cnt", 64'(ex[g]), 64'(0));
      check("poly_err_pulse", 64'(plx[g]), 64'(0));
    end

    // Single-bit error while locked
    flip = 8'h08;
    expect_chk(1'b1, 16'd1, 1'b1);
    cyc();
    flip = 8'h00;
    expect_chk(1'b1, 16'd1, 1'b0);
    cyc();

    // Clear coincident with a 2-error word wins
    flip    = 8'h21;
    clr_err = 1'b1;
    expect_chk(1'b1, 16'd0, 1'b1);
    cyc();
    clr_err = 1'b0;
    flip    = 8'h00;
    expect_chk(1'b1, 16'd0, 1'b0);
    cyc();

    // Four errored words drop lock
    flip = 8'h21;
    for (int k = 1; k <= 4; k++) begin
      expect_chk(k < 4, 16'(2 * k), 1'b1);
      cyc();
    end
    flip = 8'h00;
    for (int k = 1; k <= 8; k++) begin
      expect_chk(k == 8, 16'd8, 1'b0);
      cyc();
    end

    // Clear with no word presented
    z_ready = 1'b0;
    clr_err = 1'b1;
    expect_chk(1'b1, 16'd0, 1'b0);
    cyc();
    clr_err = 1'b0;
    z_ready = 1'b1;
    repeat (2) begin
      expect_chk(1'b1, 16'd0, 1'b0);
      cyc();
    end

    // Asynchronous reset mid-stream
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    q_z.delete();
    q_chk.delete();
    gm = 32'h7F;
    push_gen(4);
    cyc();
    rst = 1'b0;
    cyc();
    check("restart_word", 64'(z0), 64'(FIRST_W));
    expect_chk(1'b0, 16'd0, 1'b0);
    cyc();
    check("restart_second", 64'(z0), 64'(SECOND_W));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/gtech_prbs_engine.md
# gtech_prbs_engine

PRBS pattern generator plus self-synchronising checker for the GTECH generic cell library; used for BIST of datapaths that are built from GTECH primitives. The generator produces DW bits per cycle over a valid/ready interface. The checker consumes DW-bit words, locks onto the sequence and counts bit errors. Optional output/input inversion provides the ITU-T O.150 inverted PRBS variants.

## Interface
- POLY, default 7: sequence select; legal values 7, 15, 23, 31.
  - Taps: PRBS7 x^7+x^6+1, PRBS15 x^15+x^14+1, PRBS23 x^23+x^18+1, PRBS31 x^31+x^28+1.
  - Any other value is an elaboration error.
- DW, default 8: bits per word, 1..64.
- LOCK_BITS, default 64: consecutive matching bits required to lock.
- LOSS_WORDS, default 4: consecutive errored words that drop lock.

Ports:
- CP  input  1  clock, rising edge.
- RST  input  1  reset, asynchronous, active-high; clears all state.
- GEN_EN  input  1  generator enable.
- Z  output  DW  generated word; bit 0 is the oldest bit.
- Z_VALID  output  1  Z holds a valid word.
- Z_READY  input  1  downstream accepts Z.
- A  input  DW  word to check; bit 0 is the oldest bit.
- A_VALID  input  1  A is valid this cycle; there is no backpressure.
- CLR_ERR  input  1  synchronous clear of ERR_CNT.
- LOCKED  output  1  checker is locked.
- ERR_CNT  output  16  saturating count of bit errors.
- ERR_PULSE  output  1  one-cycle flag: the last checked word had at least one error while locked.

## Operation
Reset values:
- Z=0, Z_VALID=0, LOCKED=0, ERR_CNT=0, ERR_PULSE=0.
- Generator LFSR and checker LFSR both all-ones; match counter 0, loss counter 0.

LFSR step, state s[POLY-1:0]:
- Next bit b = s[T1-1] ^ s[T2-1], where T1, T2 are the taps.
- Update s <= {s[POLY-2:0], b}.

Generator:
- Load condition: GEN_EN && (!Z_VALID || Z_READY).
- On a load: advance the LFSR DW steps, Z[i] = i-th generated bit, Z_VALID <= 1.
- Else if Z_READY: Z_VALID <= 0.
- The LFSR advances only on a load.
- Z is stable while Z_VALID && !Z_READY.
- GEN_EN low never withdraws a pending word.

Checker, processing each bit of a valid word in order i = 0..DW-1; e = predicted bit from the checker state:
- SEARCH state:
  - State shifts in the received bit, not e.
  - Match counter: +1 on A[i]==e, else cleared; saturates at LOCK_BITS.
  - If the counter equals LOCK_BITS at the end of the word: go to LOCKED, loss counter <= 0.
- LOCKED state:
  - State shifts in e (free-running).
  - Mismatched bits are counted into ERR_CNT: ERR_CNT <= CLR_ERR ? 0 : min(ERR_CNT + nerr, 16'hFFFF).
  - A word with nerr>0 increments the loss counter; a word with nerr==0 clears it.
  - When the loss counter reaches LOSS_WORDS: go to SEARCH, match counter <= 0.
- CLR_ERR also acts in cycles with no A_VALID. In SEARCH, ERR_CNT does not change except by CLR_ERR.
- RST asserted mid-operation: immediate return to reset values; a pending Z word is lost.

## Timing
- Z_VALID rises on the first CP edge after RST deasserts with GEN_EN=1. Throughput is one word per cycle under continuous Z_READY.
- LOCKED, ERR_CNT and ERR_PULSE update on the CP edge that samples A_VALID, so they are visible one cycle after the word is presented.
- The full DW-bit step is combinational within one cycle; no multicycle paths.
- Loopback from reset (both LFSRs all-ones) with DW=8, LOCK_BITS=64: LOCKED rises after the 8th word.

## Configuration
- GTECH_PRBS_INVERT_EN defined:
  - Generator drives ~word on Z.
  - Checker inverts A before processing.
  - Loopback still locks with zero errors.
- GTECH_PRBS_INVERT_EN undefined: true polarity, no inversion logic.

## Test plan
- Reset, POLY=7, DW=8, GEN_EN=1, Z_READY=1 -> Z_VALID=1 first cycle after reset; Z=8'h40, then 8'h30.
- Z_READY=0 for 3 cycles after the first word -> Z holds 8'h40 and Z_VALID stays 1; on release the next word is 8'h30, with no skipped word.
- Loopback Z->A, A_VALID = Z_VALID&&Z_READY -> LOCKED=1 one cycle after the 8th word; ERR_CNT=0 over 1000 words; repeat for POLY=15, 23, 31.
- After lock, flip A[3] of one word -> ERR_CNT=1 and ERR_PULSE high for exactly one cycle; LOCKED stays 1. Then CLR_ERR in the same cycle as a 2-error word -> ERR_CNT=0.
- After lock, 4 consecutive words each with bits 0 and 5 flipped -> ERR_CNT=8 and LOCKED=0 one cycle after the 4th word; clean words afterwards -> relock after 64 matching bits. Also: RST mid-stream -> all outputs at reset values immediately.
- With GTECH_PRBS_INVERT_EN: first word Z=8'hBF, second 8'hCF; loopback locks with ERR_CNT=0.
